// File: rtl/fft_pkg.sv
// Shared types for the FFT output path: sample type, bank states, bit reversal.
// TOTAL_STAGE / CPLX_WIDTH normally come from fft_inc.sv; defaults apply when it is absent.
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 10
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

package fft_pkg;
  localparam int FFT_MAX_STAGE = 16;
  localparam int FFT_CPLX_W    = `CPLX_WIDTH;

  typedef logic [FFT_CPLX_W-1:0] cplx_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  // Reverse the low n bits of a; upper bits of a must be zero.
  function automatic logic [FFT_MAX_STAGE-1:0] bitrev(input logic [FFT_MAX_STAGE-1:0] a,
                                                      input int n);
    logic [FFT_MAX_STAGE-1:0] r;
    for (int i = 0; i < FFT_MAX_STAGE; i++) r[i] = a[FFT_MAX_STAGE-1-i];
    return r >> (FFT_MAX_STAGE - n);
  endfunction
endpackage

// File: rtl/fft_unscr_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port.
module fft_unscr_ram #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] bank_q [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we && (wbank == 1'(b))) mem[waddr] <= wdata;
    end
    assign bank_q[b] = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= bank_q[rbank];
  end
endmodule

// File: rtl/fft_unscramble.sv
// Ping-pong unscrambler: stores bit-reversed FFT frames, replays them in bin order
// over valid/ready. FFT_UNSCRAMBLE_FFTSHIFT_EN selects DC-centred read order.
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 10
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

module fft_unscramble
  import fft_pkg::*;
#(
  parameter int TOTAL_STAGE = `TOTAL_STAGE,
  parameter int CPLX_WIDTH  = `CPLX_WIDTH
) (
  input  logic                   iclk,
  input  logic                   rst,
  input  logic                   ien,
  input  logic [TOTAL_STAGE-1:0] iaddr,
  input  logic [CPLX_WIDTH-1:0]  idata,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [TOTAL_STAGE-1:0] oaddr,
  output logic [CPLX_WIDTH-1:0]  odata,
  output logic                   olast,
  output logic                   ovf
);
  localparam logic [TOTAL_STAGE-1:0] K_LAST = '1;
`ifdef FFT_UNSCRAMBLE_FFTSHIFT_EN
  localparam logic [TOTAL_STAGE-1:0] K_MASK = TOTAL_STAGE'(1 << (TOTAL_STAGE - 1));
`else
  localparam logic [TOTAL_STAGE-1:0] K_MASK = '0;
`endif

  typedef enum logic {R_IDLE, R_DRAIN} rd_st_t;

  typedef struct packed {
    logic                   last;
    logic [TOTAL_STAGE-1:0] addr;
    logic [CPLX_WIDTH-1:0]  data;
  } item_t;

  bank_st_t               bank_st [2];
  logic                   wr_bank, rd_bank, iss_bank, wr_active;
  rd_st_t                 rd_st;
  logic [TOTAL_STAGE-1:0] k, rd_addr, wr_addr, meta_addr;
  logic                   meta_last, rd_vld;
  logic [CPLX_WIDTH-1:0]  rdata;
  item_t                  skid [2];
  logic [1:0]             skid_cnt;
  item_t                  ram_item, head;
  logic                   xfer, release_now, issue, credit, start_ok, we, push, pop;
  logic [2:0]             occ_next;

  // Reader holds iss_bank (bank being read from RAM); rd_bank trails it at the
  // output and is released only when its last sample leaves.
  assign ram_item = '{last: meta_last, addr: meta_addr, data: rdata};
  assign ovalid   = (skid_cnt != 2'd0) || rd_vld;

  always_comb begin
    head = '0;
    if (skid_cnt != 2'd0) head = skid[0];
    else if (rd_vld)      head = ram_item;
  end

  assign oaddr       = head.addr;
  assign odata       = head.data;
  assign olast       = head.last;
  assign xfer        = ovalid && oready;
  assign release_now = xfer && head.last;

  // Items held after this edge (skid + RAM register) never exceed two.
  assign occ_next = 3'(skid_cnt) + 3'(rd_vld) - 3'(xfer);
  assign credit   = occ_next <= 3'd1;
  assign issue    = credit && ((rd_st == R_DRAIN) || (bank_st[iss_bank] == FULL));
  assign rd_addr  = k ^ K_MASK;

  assign push = rd_vld && !((skid_cnt == 2'd0) && xfer);
  assign pop  = xfer && (skid_cnt != 2'd0);

  // A release landing on the write bank frees it for a same-cycle frame start.
  assign wr_addr  = TOTAL_STAGE'(bitrev(FFT_MAX_STAGE'(iaddr), TOTAL_STAGE));
  assign start_ok = (bank_st[wr_bank] == EMPTY) || wr_active ||
                    (release_now && (rd_bank == wr_bank));
  assign we       = ien && ((iaddr == '0) ? start_ok : wr_active);

  fft_unscr_ram #(.AW(TOTAL_STAGE), .DW(CPLX_WIDTH)) u_ram (
    .clk   (iclk),
    .we    (we),
    .wbank (wr_bank),
    .waddr (wr_addr),
    .wdata (idata),
    .re    (issue),
    .rbank (iss_bank),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  always_ff @(posedge iclk) begin
    if (rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      iss_bank   <= 1'b0;
      wr_active  <= 1'b0;
      ovf        <= 1'b0;
      rd_st      <= R_IDLE;
      k          <= '0;
      rd_vld     <= 1'b0;
      meta_addr  <= '0;
      meta_last  <= 1'b0;
      skid[0]    <= '0;
      skid[1]    <= '0;
      skid_cnt   <= 2'd0;
    end else begin
      if (release_now) begin
        bank_st[rd_bank] <= EMPTY;
        rd_bank          <= ~rd_bank;
      end

      if (ien) begin
        if (iaddr == '0) begin
          if (start_ok) begin
            bank_st[wr_bank] <= FILLING;
            wr_active        <= 1'b1;
          end else begin
            ovf       <= 1'b1;
            wr_active <= 1'b0;
          end
        end else if (wr_active && (iaddr == K_LAST)) begin
          bank_st[wr_bank] <= FULL;
          wr_bank          <= ~wr_bank;
          wr_active        <= 1'b0;
        end
      end

      if (issue) begin
        if (rd_st == R_IDLE) bank_st[iss_bank] <= DRAINING;
        if (k == K_LAST) begin
          k        <= '0;
          iss_bank <= ~iss_bank;
          rd_st    <= R_IDLE;
        end else begin
          k     <= k + TOTAL_STAGE'(1);
          rd_st <= R_DRAIN;
        end
        meta_addr <= rd_addr;
        meta_last <= (k == K_LAST);
      end
      rd_vld <= issue;

      if (pop) skid[0] <= skid[1];
      if (push) begin
        if (pop) begin
          if (skid_cnt == 2'd2) skid[1] <= ram_item;
          else                  skid[0] <= ram_item;
        end else begin
          if (skid_cnt == 2'd0) skid[0] <= ram_item;
          else                  skid[1] <= ram_item;
        end
      end
      skid_cnt <= skid_cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_fft_unscramble.sv
// Directed bench for fft_unscramble with N=8; frame tag in re[15:8], im = ~re.
module tb_fft_unscramble;
  logic        iclk = 1'b0;
  logic        rst, ien, oready;
  logic [2:0]  iaddr, oaddr;
  logic [31:0] idata, odata;
  logic        ovalid, olast, ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int p;
    int k;
    int re;
    bit last;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } cap_t;

  vec_t tbl [8];
  cap_t cap_q [$];

  bit          stall_prev;
  logic [2:0]  prev_addr;
  logic [31:0] prev_data;
  logic        prev_last;

  fft_unscramble #(.TOTAL_STAGE(3), .CPLX_WIDTH(32)) dut (
    .iclk   (iclk),
    .rst    (rst),
    .ien    (ien),
    .iaddr  (iaddr),
    .idata  (idata),
    .ovalid (ovalid),
    .oready (oready),
    .oaddr  (oaddr),
    .odata  (odata),
    .olast  (olast),
    .ovf    (ovf)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: captures transfers and checks hold-stability under stall.
  always @(negedge iclk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(ovalid), 32'd1);
        chk("stall_addr", 32'(oaddr), 32'(prev_addr));
        chk("stall_data", odata, prev_data);
        chk("stall_last", 32'(olast), 32'(prev_last));
      end
      if (ovalid && oready)
        cap_q.push_back('{addr: oaddr, data: odata, last: olast, cyc: cyc});
      stall_prev <= ovalid && !oready;
      prev_addr  <= oaddr;
      prev_data  <= odata;
      prev_last  <= olast;
    end
  end

  task automatic send_beats(input int tag, input int from, input int to);
    logic [15:0] re;
    for (int p = from; p <= to; p++) begin
      re    = 16'((tag << 8) | tbl[p].p);
      ien   = 1'b1;
      iaddr = 3'(tbl[p].p);
      idata = {re, ~re};
      @(posedge iclk); #1;
    end
    ien = 1'b0;
  endtask

  task automatic wait_cap(input int n, input int budget);
    int c = 0;
    while (cap_q.size() < n && c < budget) begin
      @(posedge iclk); #1;
      c++;
    end
    if (cap_q.size() < n) chk("wait_timeout", 32'(cap_q.size()), 32'(n));
  endtask

  task automatic check_frame(input int tag);
    cap_t        c;
    logic [15:0] re;
    for (int i = 0; i < 8; i++) begin
      if (cap_q.size() == 0) begin
        chk($sformatf("f%0d_count", tag), 32'(i), 32'd8);
        return;
      end
      c  = cap_q.pop_front();
      re = 16'((tag << 8) | tbl[i].re);
      chk($sformatf("f%0d_b%0d_addr", tag, i), 32'(c.addr), 32'(tbl[i].k));
      chk($sformatf("f%0d_b%0d_data", tag, i), c.data, {re, ~re});
      chk($sformatf("f%0d_b%0d_last", tag, i), 32'(c.last), 32'(tbl[i].last));
    end
  endtask

  task automatic check_idle(input string name);
    repeat (20) @(posedge iclk);
    #1;
    chk(name, 32'(cap_q.size()), 32'd0);
    cap_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
`ifdef FFT_UNSCRAMBLE_FFTSHIFT_EN
    tbl = '{'{0, 4, 1, 0}, '{1, 5, 5, 0}, '{2, 6, 3, 0}, '{3, 7, 7, 0},
            '{4, 0, 0, 0}, '{5, 1, 4, 0}, '{6, 2, 2, 0}, '{7, 3, 6, 1}};
`else
    tbl = '{'{0, 0, 0, 0}, '{1, 1, 4, 0}, '{2, 2, 2, 0}, '{3, 3, 6, 0},
            '{4, 4, 1, 0}, '{5, 5, 5, 0}, '{6, 6, 3, 0}, '{7, 7, 7, 1}};
`endif
    rst = 1'b1; ien = 1'b0; iaddr = '0; idata = '0; oready = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_oaddr", 32'(oaddr), 32'd0);
    chk("rst_odata", odata, 32'd0);
    chk("rst_olast", 32'(olast), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge iclk); #1;

    // Single frame, consumer always ready; first sample one cycle after the last write.
    send_beats(1, 0, 7);
    chk("lat_pre_valid", 32'(ovalid), 32'd0);
    @(posedge iclk); #1;
    chk("lat_first_valid", 32'(ovalid), 32'd1);
    chk("lat_first_addr", 32'(oaddr), 32'(tbl[0].k));
    wait_cap(8, 40);
    check_frame(1);
    chk("single_ovf", 32'(ovf), 32'd0);
    check_idle("single_no_extra");

    // Three contiguous frames: no drop, no bubble.
    send_beats(2, 0, 7);
    send_beats(3, 0, 7);
    send_beats(4, 0, 7);
    wait_cap(24, 80);
    gaps = 0;
    for (int i = 1; i < cap_q.size(); i++)
      if (cap_q[i].cyc != cap_q[i-1].cyc + 1) gaps++;
    chk("b2b_no_bubble", 32'(gaps), 32'd0);
    check_frame(2);
    check_frame(3);
    check_frame(4);
    chk("b2b_ovf", 32'(ovf), 32'd0);
    check_idle("b2b_no_extra");

    // Back-pressure 1,0,0 repeating.
    fork
      begin
        send_beats(5, 0, 7);
        send_beats(6, 0, 7);
      end
      begin
        int i = 0;
        while (cap_q.size() < 16 && i < 300) begin
          oready = (i % 3 == 0);
          @(posedge iclk); #1;
          i++;
        end
        oready = 1'b1;
      end
    join
    check_frame(5);
    check_frame(6);
    chk("bp_ovf", 32'(ovf), 32'd0);
    check_idle("bp_no_extra");

    // Overflow: consumer stalled across three frames; third is dropped.
    oready = 1'b0;
    send_beats(7, 0, 7);
    send_beats(8, 0, 7);
    chk("ovf_before", 32'(ovf), 32'd0);
    send_beats(9, 0, 0);
    chk("ovf_at_p0", 32'(ovf), 32'd1);
    send_beats(9, 1, 7);
    oready = 1'b1;
    wait_cap(16, 80);
    check_frame(7);
    check_frame(8);
    check_idle("ovf_no_extra");
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Reset on the fifth output beat, then a partial frame and a full frame.
    send_beats(12, 0, 7);
    begin
      int c = 0;
      while (cap_q.size() < 4 && c < 40) begin
        @(posedge iclk); #1;
        c++;
      end
      chk("mid_reach_k4", 32'(cap_q.size()), 32'd4);
    end
    rst = 1'b1;
    @(posedge iclk); #1;
    chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_oaddr", 32'(oaddr), 32'd0);
    chk("mid_rst_olast", 32'(olast), 32'd0);
    rst = 1'b0;
    cap_q.delete();
    send_beats(13, 3, 7);
    send_beats(14, 0, 7);
    wait_cap(8, 40);
    check_frame(14);
    check_idle("mid_no_extra");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
